// File: rtl/if_ctrl_pkg.sv
// Shared types and constants for the IF/RF front-end sequencer.
package if_ctrl_pkg;

  // FSM encoding; RUN/WAIT_MEM/HOLD differ only in the recorded stall reason.
  typedef enum logic [1:0] {
    ST_BOOT     = 2'd0,
    ST_RUN      = 2'd1,
    ST_WAIT_MEM = 2'd2,
    ST_HOLD     = 2'd3
  } if_ctrl_state_t;

  // Instruction muxed into IF/RF when a bubble is inserted.
  localparam logic [31:0] NOP_INSTR = 32'hD503201F;

  // Sequential PC increment used by the datapath adder.
  localparam logic [63:0] PC_STEP = 64'd4;

endpackage

// File: rtl/if_rf_ctrl_sat_counter.sv
// Saturating up-counter used for front-end performance statistics.
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_inc,
  output logic [WIDTH-1:0] o_count
);

  localparam logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}};

  logic [WIDTH-1:0] r_count;

  // Count increment requests, sticking at all-ones instead of wrapping.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= {WIDTH{1'b0}};
    end else if (i_inc && (r_count != MAX_VAL)) begin
      r_count <= r_count + WIDTH'(1);
    end else begin
      r_count <= r_count;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/if_rf_ctrl.sv
// PC / IF-RF pipeline register sequencer: arbitrates redirect, load-use
// hazard and instruction-memory wait, and drives the PC and NOP mux selects.
module if_rf_ctrl
  import if_ctrl_pkg::*;
#(
  parameter int BOOT_CYCLES = 2,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             imem_ready,
  input  logic             hazard_stall,
  input  logic             redirect,
  output logic             imem_req,
  output logic             pc_sel,
  output logic             pc_write,
  output logic             ifrf_write,
  output logic             ifrf_bubble,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] bubble_count
);

  localparam logic [3:0] BOOT_LAST = 4'(BOOT_CYCLES - 1);

  if_ctrl_state_t r_state;
  if_ctrl_state_t w_next_state;
  logic [3:0]     r_boot_cnt;
  logic           w_boot_done;
  logic           w_stall_inc;

  assign w_boot_done = (r_boot_cnt == BOOT_LAST);

  // State register; reset always re-enters BOOT and drops any pending stall.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_BOOT;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Boot idle counter; only runs while in BOOT and clears on exit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_boot_cnt <= 4'd0;
    end else if ((r_state == ST_BOOT) && !w_boot_done) begin
      r_boot_cnt <= r_boot_cnt + 4'd1;
    end else begin
      r_boot_cnt <= 4'd0;
    end
  end

  // Mealy priority decode: redirect > hazard > memory wait > normal fetch.
  always_comb begin
    w_next_state = r_state;
    imem_req     = 1'b0;
    pc_sel       = 1'b0;
    pc_write     = 1'b0;
    ifrf_write   = 1'b0;
    ifrf_bubble  = 1'b0;
    case (r_state)
      ST_BOOT: begin
        if (w_boot_done) begin
          w_next_state = ST_RUN;
        end else begin
          w_next_state = ST_BOOT;
        end
      end
      ST_RUN, ST_WAIT_MEM, ST_HOLD: begin
        imem_req = 1'b1;
        if (redirect) begin
          // Wrong-path hazard in the same cycle is discarded.
          pc_sel       = 1'b1;
          pc_write     = 1'b1;
          ifrf_write   = 1'b1;
          ifrf_bubble  = 1'b1;
          w_next_state = ST_RUN;
        end else if (hazard_stall) begin
          // Freeze PC and IF/RF; any fetched word is refetched later.
          w_next_state = ST_HOLD;
        end else if (!imem_ready) begin
          // Load a NOP so decode never re-executes the stale instruction.
          ifrf_write   = 1'b1;
          ifrf_bubble  = 1'b1;
          w_next_state = ST_WAIT_MEM;
        end else begin
          pc_write     = 1'b1;
          ifrf_write   = 1'b1;
          w_next_state = ST_RUN;
        end
      end
      default: begin
        w_next_state = ST_BOOT;
      end
    endcase
  end

  assign state       = r_state;
  assign w_stall_inc = (r_state != ST_BOOT) && !pc_write;

  sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
    .i_clk   (clk),
    .i_rst_n (reset),
    .i_inc   (w_stall_inc),
    .o_count (stall_count)
  );

  sat_counter #(.WIDTH(CNT_W)) u_bubble_cnt (
    .i_clk   (clk),
    .i_rst_n (reset),
    .i_inc   (ifrf_bubble),
    .o_count (bubble_count)
  );

endmodule

// File: doc/if_rf_ctrl.md
# if_rf_ctrl

Front-end sequencer for the IF/RF pipeline register and the PC register. Each cycle it decides whether the PC advances, holds, or loads a branch target, and whether IF/RF captures the fetched instruction, holds, or captures a NOP bubble. It arbitrates three stall/flush sources: taken-branch redirect, decode load-use hazard, and instruction-memory wait. It sits between fetch, instruction memory, decode hazard logic and the branch-resolve stage, and keeps saturating stall/bubble counters for performance debug.

## Interface
- BOOT_CYCLES, default 2: cycles held idle after reset release before the first fetch (1..15).
- CNT_W, default 32: width of the performance counters.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low; 0 forces the reset state immediately.
- imem_ready  in  1  instruction memory returns a valid instruction for the current PC this cycle.
- hazard_stall  in  1  decode load-use hazard; the instruction in decode must be held.
- redirect  in  1  taken branch resolved; the PC must load the branch target.
- imem_req  out  1  fetch request for the current PC.
- pc_sel  out  1  1 selects the branch target as the PC next value; 0 selects PC+4.
- pc_write  out  1  PC register write enable.
- ifrf_write  out  1  IF/RF register write enable.
- ifrf_bubble  out  1  1 muxes NOP_INSTR (32'hD503201F) onto the IF/RF instruction input.
- state  out  2  current FSM state, for debug.
- stall_count  out  CNT_W  cycles with pc_write=0 while not in BOOT; saturates.
- bubble_count  out  CNT_W  cycles with ifrf_bubble=1; saturates.

## Operation
- States:
  - BOOT=0
  - RUN=1
  - WAIT_MEM=2
  - HOLD=3
- BOOT:
  - All control outputs are 0.
  - A 4-bit boot counter counts from 0. The FSM moves to RUN on the edge where the counter reaches BOOT_CYCLES-1.
  - redirect, hazard_stall and imem_ready are ignored.
- RUN, WAIT_MEM and HOLD share one priority decision. imem_req=1 in all three. The first matching row applies:
  1. redirect=1:
     - Outputs: pc_sel=1, pc_write=1, ifrf_write=1, ifrf_bubble=1.
     - Next state: RUN.
     - Any outstanding fetch is abandoned; memory restarts on the new PC.
     - A hazard in the same cycle is discarded because it belongs to the wrong path.
  2. hazard_stall=1:
     - Outputs: pc_write=0, ifrf_write=0, ifrf_bubble=0.
     - Next state: HOLD.
     - The fetched instruction, if any, is dropped and refetched later.
  3. imem_ready=0:
     - Outputs: pc_write=0, ifrf_write=1, ifrf_bubble=1, so decode never re-executes the stale instruction.
     - Next state: WAIT_MEM.
  4. Otherwise:
     - Outputs: pc_sel=0, pc_write=1, ifrf_write=1, ifrf_bubble=0.
     - Next state: RUN.
- pc_sel=0 whenever redirect is not the active row.
- The state register records the reason for the last stall only. Behaviour in RUN, WAIT_MEM and HOLD is identical for identical inputs.
- Counters:
  - stall_count increments on each edge where the state is not BOOT and pc_write=0.
  - bubble_count increments on each edge where ifrf_bubble=1.
  - Both stop at all-ones and never wrap.

## Timing
- Outputs are Mealy: combinational from the state and current inputs, valid in the same cycle.
- Redirect latency: the PC holds the target and IF/RF holds the NOP after the next edge, so exactly one bubble is inserted per redirect.
- Hazard: the PC and IF/RF are frozen for exactly as many cycles as hazard_stall is high. Fetch resumes in the cycle hazard_stall falls.
- Memory wait of N cycles (imem_ready low N cycles) gives N bubbles and N stall_count increments.
- Reset values, asserted asynchronously while reset=0:
  - State: BOOT.
  - Boot counter: 0.
  - stall_count and bubble_count: 0.
  - imem_req, pc_sel, pc_write, ifrf_write, ifrf_bubble: 0.
- Reset asserted mid-operation:
  - Takes effect immediately without waiting for a clock edge.
  - Any pending wait or hold is discarded.
  - Re-entry always passes through BOOT for the full BOOT_CYCLES.
- First fetch: imem_req rises in cycle BOOT_CYCLES after reset release, counting the first clk edge with reset=1 as edge 1.

## Structure
- Shared package if_ctrl_pkg holds:
  - Typedef if_ctrl_state_t, a 2-bit enum with the encodings above.
  - Constant NOP_INSTR = 32'hD503201F.
  - Constant PC_STEP = 64'd4.
- Sub-module sat_counter, parameterised by width, with an increment input and a saturating output. It is instantiated twice, for stall_count and bubble_count.
- FSM register and priority decode live in if_rf_ctrl.
- The PC mux and the NOP mux stay in the datapath; this block drives only their selects.

## Test plan
- Reset sequence:
  - Stimulus: hold reset=0 for 3 cycles, release, BOOT_CYCLES=2.
  - Response: all outputs 0 and state=0 through 1 edge after release; state=1 and imem_req=1 from the 2nd edge; counters remain 0.
- Steady fetch:
  - Stimulus: imem_ready=1 for 10 cycles.
  - Response: pc_write=1, ifrf_write=1 and ifrf_bubble=0 every cycle; stall_count=0.
- Memory wait:
  - Stimulus: imem_ready=0 for 3 cycles.
  - Response: 3 cycles of pc_write=0 and ifrf_bubble=1; state=2; stall_count=3 and bubble_count=3 afterwards.
- Redirect versus hazard:
  - Stimulus: redirect=1 and hazard_stall=1 in the same cycle.
  - Response: pc_sel=1, pc_write=1, ifrf_bubble=1; next state=1; bubble_count +1; stall_count unchanged.
- Load-use hold:
  - Stimulus: hazard_stall=1 for 2 cycles with imem_ready=1.
  - Response: pc_write=0 and ifrf_write=0 both cycles; state=3; normal fetch in cycle 3.
- Saturation and reset mid-wait:
  - Stimulus: force stall_count to all-ones minus 1, then stall 3 cycles; then pull reset=0 while in WAIT_MEM.
  - Response: the counter holds all-ones; reset forces state=0 and all outputs 0 asynchronously.
